// File: rtl/mix_reduce_pipe.sv
// Pipelined binary-tree reducer: folds NUM_IN words into one per beat with XOR or
// modular ADD, optional running accumulation in out0, and a saturating result count.
module mix_reduce_pipe #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     in_valid,
  input  logic [1:0]               mode,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [DATA_W-1:0]        out0,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         count
);

  localparam int LEVELS = $clog2(NUM_IN);
  localparam int NODES  = NUM_IN - 1;

  function automatic int node_depth(input int idx);
    int d;
    int n;
    d = 0;
    n = idx + 1;
    while (n > 1) begin
      n = n >> 1;
      d++;
    end
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] combine(input logic op_add,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return op_add ? (a + b) : (a ^ b);
  endfunction

  logic [LEVELS-1:0] vld_pipe;
  logic [1:0]        mode_pipe [LEVELS];
  logic [DATA_W-1:0] node_val  [NODES];

  // Valid and mode shift alongside the data so each beat keeps its own operator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      for (int k = 0; k < LEVELS; k++) mode_pipe[k] <= 2'b00;
    end else if (run) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_valid;
      mode_pipe[0] <= mode;
      for (int k = 1; k < LEVELS; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        mode_pipe[k] <= mode_pipe[k-1];
      end
    end
  end

  // Heap-ordered tree: node i has children 2i+1/2i+2, leaves map to in_data words.
  for (genvar i = 0; i < NODES; i++) begin : g_node
    localparam int STG = LEVELS - node_depth(i);
    localparam int LC  = 2*i + 1;
    localparam int RC  = 2*i + 2;

    logic [DATA_W-1:0] lhs;
    logic [DATA_W-1:0] rhs;
    logic [DATA_W-1:0] node_q;
    logic              op_add;

    if (LC >= NODES) begin : g_leaf
      assign lhs = in_data[(LC-NODES)*DATA_W +: DATA_W];
      assign rhs = in_data[(RC-NODES)*DATA_W +: DATA_W];
    end else begin : g_inner
      assign lhs = node_val[LC];
      assign rhs = node_val[RC];
    end

    if (STG == 1) begin : g_op_in
      assign op_add = mode[0];
    end else begin : g_op_pipe
      assign op_add = mode_pipe[STG-2][0];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) node_q <= '0;
      else      node_q <= combine(op_add, lhs, rhs);
    end

    assign node_val[i] = node_q;
  end

  logic              fin_vld;
  logic [1:0]        fin_mode;
  logic [DATA_W-1:0] root;

  assign fin_vld  = vld_pipe[LEVELS-1];
  assign fin_mode = mode_pipe[LEVELS-1];
  assign root     = node_val[0];

  // out0 doubles as the accumulator, so accumulate after pass seeds from the last output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out0      <= '0;
      out_valid <= 1'b0;
      count     <= '0;
    end else if (run) begin
      out0      <= '0;
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      out_valid <= fin_vld;
      if (fin_vld) begin
        out0 <= fin_mode[1] ? combine(fin_mode[0], out0, root) : root;
        if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mix_reduce_pipe.sv
// Randomized and directed bench for mix_reduce_pipe against a queue-based reference
// model; a second instance with a 2-bit counter shares the same stimulus.
module tb_mix_reduce_pipe;

  localparam int DATA_W = 32;
  localparam int NUM_IN = 4;
  localparam int LEVELS = 2;

  logic                     clk;
  logic                     rst;
  logic                     run;
  logic                     in_valid;
  logic [1:0]               mode;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [DATA_W-1:0]        out0, out0_b;
  logic                     out_valid, out_valid_b;
  logic [15:0]              count;
  logic [1:0]               count_b;

  mix_reduce_pipe #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .in_valid(in_valid), .mode(mode),
    .in_data(in_data), .out0(out0), .out_valid(out_valid), .count(count)
  );

  mix_reduce_pipe #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .run(run), .in_valid(in_valid), .mode(mode),
    .in_data(in_data), .out0(out0_b), .out_valid(out_valid_b), .count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [127:0] pack(input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [31:0] reduce(input logic [127:0] d, input logic add);
    logic [31:0] r;
    logic [31:0] w;
    r = d[31:0];
    for (int i = 1; i < NUM_IN; i++) begin
      w = d[i*32 +: 32];
      r = add ? r + w : r ^ w;
    end
    return r;
  endfunction

  // Reference model: each accepted beat is queued with its completion edge.
  typedef struct {
    int          due;
    logic [31:0] res;
    logic [1:0]  md;
  } beat_t;

  beat_t       q[$];
  beat_t       cur;
  int          cyc = 0;
  logic [31:0] m_out0 = 0;
  logic        m_valid = 0;
  int          m_cnt = 0;
  int          m_cnt_b = 0;
  logic        s_rst, s_run, s_vld;
  logic [1:0]  s_mode;
  logic [127:0] s_data;

  always @(posedge clk) begin
    s_rst = rst; s_run = run; s_vld = in_valid; s_mode = mode; s_data = in_data;
    #1;
    cyc++;
    if (!s_rst || s_run) begin
      q.delete();
      m_out0 = 0; m_valid = 0; m_cnt = 0; m_cnt_b = 0;
    end else begin
      m_valid = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        cur = q.pop_front();
        if (cur.md[1]) m_out0 = cur.md[0] ? m_out0 + cur.res : m_out0 ^ cur.res;
        else           m_out0 = cur.res;
        m_valid = 1;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_b < 3)   m_cnt_b++;
      end
      if (s_vld) begin
        cur.due = cyc + LEVELS;
        cur.res = reduce(s_data, s_mode[0]);
        cur.md  = s_mode;
        q.push_back(cur);
      end
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("out0", out0, m_out0);
    chk("count", {16'b0, count}, m_cnt);
    chk("out_valid_sat", {31'b0, out_valid_b}, {31'b0, m_valid});
    chk("out0_sat", out0_b, m_out0);
    chk("count_sat", {30'b0, count_b}, m_cnt_b);
  end

  task automatic beat(input logic [127:0] d, input logic [1:0] m);
    @(negedge clk);
    run = 0; in_valid = 1; in_data = d; mode = m;
  endtask

  task automatic pulse_run(input logic with_beat);
    @(negedge clk);
    run = 1; in_valid = with_beat; in_data = {$urandom, $urandom, $urandom, $urandom};
    mode = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      run = 0; in_valid = 0;
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    run = 0; in_valid = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1; run = 0; in_valid = 0; mode = 0; in_data = '0;
    #3 rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_out0", out0, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_count", {16'b0, count}, 0);
    rst = 1;

    beat(pack(1, 2, 4, 8), 2'd0);
    wait_valid();
    chk("xor_pass", out0, 32'h0000_000F);
    chk("xor_pass_count", {16'b0, count}, 1);

    beat(pack(32'hFFFF_FFFF, 1, 0, 0), 2'd1);
    wait_valid();
    chk("add_wrap", out0, 32'h0000_0000);
    beat(pack(32'h8000_0000, 32'h8000_0000, 3, 4), 2'd1);
    wait_valid();
    chk("add_wrap2", out0, 32'h0000_0007);

    pulse_run(1'b0);
    beat(pack(32'h0F, 0, 0, 0), 2'd2);
    beat(pack(32'hF0, 0, 0, 0), 2'd2);
    beat(pack(32'hFF, 0, 0, 0), 2'd2);
    wait_valid();
    chk("acc_0", out0, 32'h0F);
    @(posedge clk); #1;
    chk("acc_1_valid", {31'b0, out_valid}, 1);
    chk("acc_1", out0, 32'hFF);
    @(posedge clk); #1;
    chk("acc_2_valid", {31'b0, out_valid}, 1);
    chk("acc_2", out0, 32'h00);
    chk("acc_count", {16'b0, count}, 3);

    beat(pack(1, 1, 1, 1), 2'd1);
    beat(pack(1, 1, 1, 1), 2'd0);
    wait_valid();
    chk("mode_chg_a", out0, 32'd4);
    @(posedge clk); #1;
    chk("mode_chg_b_valid", {31'b0, out_valid}, 1);
    chk("mode_chg_b", out0, 32'd0);

    beat({$urandom, $urandom, $urandom, $urandom}, 2'd0);
    beat({$urandom, $urandom, $urandom, $urandom}, 2'd1);
    pulse_run(1'b1);
    idle(5);
    chk("run_out0", out0, 0);
    chk("run_count", {16'b0, count}, 0);
    beat(pack(5, 6, 0, 0), 2'd1);
    wait_valid();
    chk("run_after", out0, 32'd11);
    chk("run_after_count", {16'b0, count}, 1);

    pulse_run(1'b0);
    repeat (5) beat(pack(9, 0, 0, 0), 2'd0);
    idle(6);
    chk("sat_count_b", {30'b0, count_b}, 3);
    chk("sat_count", {16'b0, count}, 5);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      run      = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      in_data  = {$urandom, $urandom, $urandom, $urandom};
    end

    beat({$urandom, $urandom, $urandom, $urandom}, 2'd3);
    beat({$urandom, $urandom, $urandom, $urandom}, 2'd1);
    @(negedge clk);
    in_valid = 0; run = 0; rst = 0;
    #1;
    chk("midrst_out0", out0, 0);
    chk("midrst_out_valid", {31'b0, out_valid}, 0);
    chk("midrst_count", {16'b0, count}, 0);
    @(negedge clk);
    rst = 1;
    idle(5);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
